// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel edge detector.
// One 8-bit pixel in per input handshake, one result pixel out per output
// handshake, raster order. Two line buffers feed a 3x3 window; the result for
// pixel k is loaded into the output register when pixel k+WIDTH+1 is accepted.
// The last WIDTH+1 results of a frame are all border zeros and are drained in
// FLUSH without further input.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge when
// valid and ready are both high; a source holds valid and data stable until
// that transfer, and ready may depend combinationally on the far side's ready.
module sobel_stream #(
   parameter int WIDTH = 640,
   parameter int DEPTH = 480
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] threshold,
   input  logic       mode,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_last,
   input  logic       out_ready,
   output logic [1:0] o_dbg_state
);

   localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int YW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(DEPTH - 1);
   localparam logic [YW-1:0] Y_ONE  = YW'(1);

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t         r_state;
   logic [XW-1:0]  r_ix;
   logic [YW-1:0]  r_iy;
   logic [XW-1:0]  r_ox;
   logic [YW-1:0]  r_oy;
   logic [7:0]     r_thr;
   logic           r_mode;
   logic           r_out_valid;
   logic [7:0]     r_out_data;
   logic           r_out_last;

   // Line buffers: r_lb0 holds the row above the incoming pixel, r_lb1 the
   // row above that. Indexed by column.
   logic [7:0]     r_lb0 [WIDTH];
   logic [7:0]     r_lb1 [WIDTH];

   // Two previously accepted columns of the window (t = top, m = mid, b = bottom).
   // r_wa is two columns left of the incoming pixel, r_wb one column left.
   logic [7:0]     r_wa_t, r_wa_m, r_wa_b;
   logic [7:0]     r_wb_t, r_wb_m, r_wb_b;

   logic           w_in_ready;
   logic           w_acc;
   logic           w_fire;
   logic           w_load;
   logic           w_flush_load;
   logic           w_in_last;
   logic           w_in_fill_done;
   logic           w_first_pix;
   logic [7:0]     w_nc_t, w_nc_m, w_nc_b;
   logic [9:0]     w_sum_l, w_sum_r, w_sum_t, w_sum_b;
   logic signed [10:0] w_gx, w_gy;
   logic [10:0]    w_ax, w_ay, w_mag;
   logic           w_border;
   logic           w_o_last;
   logic [7:0]     w_sat;
   logic [7:0]     w_bin;
   logic [7:0]     w_pix;

   assign w_acc          = in_valid && w_in_ready;
   assign w_fire         = r_out_valid && out_ready;
   assign w_in_last      = (r_ix == X_LAST) && (r_iy == Y_LAST);
   assign w_in_fill_done = (r_ix == '0) && (r_iy == Y_ONE);
   assign w_first_pix    = (r_ix == '0) && (r_iy == '0);

   // Incoming window column: two rows up, one row up, current pixel.
   assign w_nc_t = r_lb1[r_ix];
   assign w_nc_m = r_lb0[r_ix];
   assign w_nc_b = in_data;

   // Weighted 1-2-1 sums of the window's outer columns and rows (max 1020).
   assign w_sum_l = {2'b00, r_wa_t} + {1'b0, r_wa_m, 1'b0} + {2'b00, r_wa_b};
   assign w_sum_r = {2'b00, w_nc_t} + {1'b0, w_nc_m, 1'b0} + {2'b00, w_nc_b};
   assign w_sum_t = {2'b00, r_wa_t} + {1'b0, r_wb_t, 1'b0} + {2'b00, w_nc_t};
   assign w_sum_b = {2'b00, r_wa_b} + {1'b0, r_wb_b, 1'b0} + {2'b00, w_nc_b};

   assign w_gx = $signed({1'b0, w_sum_r}) - $signed({1'b0, w_sum_l});
   assign w_gy = $signed({1'b0, w_sum_b}) - $signed({1'b0, w_sum_t});

   assign w_ax  = w_gx[10] ? $unsigned(-w_gx) : $unsigned(w_gx);
   assign w_ay  = w_gy[10] ? $unsigned(-w_gy) : $unsigned(w_gy);
   assign w_mag = w_ax + w_ay;

   assign w_sat = (w_mag > 11'd255) ? 8'hFF : w_mag[7:0];
   assign w_bin = (w_mag > {3'b000, r_thr}) ? 8'hFF : 8'h00;

   // Border test uses the coordinates of the output being loaded, so stale
   // window or line-buffer contents can never reach the output.
   assign w_border = (r_ox == '0) || (r_ox == X_LAST) || (r_oy == '0) || (r_oy == Y_LAST);
   assign w_o_last = (r_ox == X_LAST) && (r_oy == Y_LAST);
   assign w_pix    = w_border ? 8'h00 : (r_mode ? w_sat : w_bin);

   // In FLUSH, load the next result whenever the output register is free or
   // being emptied, until the frame's last result sits in it.
   assign w_flush_load = (r_state == S_FLUSH) && !(r_out_valid && r_out_last) &&
                         (!r_out_valid || out_ready);
   assign w_load       = ((r_state == S_RUN) && w_acc) || w_flush_load;

   // Input acceptance depends on state and whether the output register can take a result.
   always_comb begin
      w_in_ready = 1'b0;
      case (r_state)
         S_FILL:  w_in_ready = 1'b1;
         S_RUN:   w_in_ready = !r_out_valid || out_ready;
         S_FLUSH: w_in_ready = 1'b0;
         default: w_in_ready = 1'b0;
      endcase
   end

   // Input raster position, wrapping at the end of each frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ix <= '0;
         r_iy <= '0;
      end else if (w_acc) begin
         if (r_ix == X_LAST) begin
            r_ix <= '0;
            r_iy <= (r_iy == Y_LAST) ? '0 : r_iy + 1'b1;
         end else begin
            r_ix <= r_ix + 1'b1;
         end
      end
   end

   // Frame parameters are captured with pixel 0 and held for the whole frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_thr  <= 8'h00;
         r_mode <= 1'b0;
      end else if (w_acc && w_first_pix) begin
         r_thr  <= threshold;
         r_mode <= mode;
      end
   end

   // Raster position of the next result to be loaded into the output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ox <= '0;
         r_oy <= '0;
      end else if (w_load) begin
         if (r_ox == X_LAST) begin
            r_ox <= '0;
            r_oy <= (r_oy == Y_LAST) ? '0 : r_oy + 1'b1;
         end else begin
            r_ox <= r_ox + 1'b1;
         end
      end
   end

   // Line buffers and window shift on every accepted pixel; contents need no reset.
   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_lb1[r_ix] <= r_lb0[r_ix];
         r_lb0[r_ix] <= in_data;
         r_wa_t      <= r_wb_t;
         r_wa_m      <= r_wb_m;
         r_wa_b      <= r_wb_b;
         r_wb_t      <= w_nc_t;
         r_wb_m      <= w_nc_m;
         r_wb_b      <= w_nc_b;
      end
   end

   // Frame sequencing FSM with the registered output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_FILL;
         r_out_valid <= 1'b0;
         r_out_data  <= 8'h00;
         r_out_last  <= 1'b0;
      end else begin
         case (r_state)
            S_FILL: begin
               if (w_acc && w_in_fill_done) begin
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_acc) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_pix;
                  r_out_last  <= w_o_last;
                  if (w_in_last) begin
                     r_state <= S_FLUSH;
                  end
               end else if (w_fire) begin
                  r_out_valid <= 1'b0;
               end
            end
            S_FLUSH: begin
               if (w_fire && r_out_last) begin
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
                  r_state     <= S_FILL;
               end else if (w_flush_load) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_pix;
                  r_out_last  <= w_o_last;
               end
            end
            default: begin
               r_state     <= S_FILL;
               r_out_valid <= 1'b0;
               r_out_last  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = w_in_ready;
   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign out_last    = r_out_last;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream: bench for sobel_stream with a 4x4 instance (hand-derived
// vector table) and an 8x6 instance (random frames against an arithmetic
// reference model, random valid/ready, mid-frame reset).
module tb_sobel_stream;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [7:0] threshold;
   logic       mode;
   logic       in_valid  [2];
   logic [7:0] in_data   [2];
   logic       in_ready  [2];
   logic       out_valid [2];
   logic [7:0] out_data  [2];
   logic       out_last  [2];
   logic       out_ready [2];
   logic [1:0] dbg_state [2];

   sobel_stream #(.WIDTH(4), .DEPTH(4)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .threshold(threshold), .mode(mode),
      .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
      .out_valid(out_valid[0]), .out_data(out_data[0]), .out_last(out_last[0]),
      .out_ready(out_ready[0]), .o_dbg_state(dbg_state[0])
   );

   sobel_stream #(.WIDTH(8), .DEPTH(6)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .threshold(threshold), .mode(mode),
      .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
      .out_valid(out_valid[1]), .out_data(out_data[1]), .out_last(out_last[1]),
      .out_ready(out_ready[1]), .o_dbg_state(dbg_state[1])
   );

   // ---------------- scoreboard state ----------------
   typedef struct packed {
      logic [7:0] d;
      logic [7:0] thr;
      logic       md;
   } drv_t;

   typedef struct {
      int         pat;
      logic       md;
      logic [7:0] thr;
      logic [7:0] exp_in;
   } vec_t;

   int         n_chk;
   int         n_err;
   drv_t       drv_q [$];
   logic [8:0] exp_q [$];
   logic [7:0] fr    [48];
   int         acc_cnt;
   bit         flushing;
   vec_t       vt    [8];

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int px(input int x, input int y, input int w);
      return int'(fr[y*w + x]);
   endfunction

   function automatic void model_frame(input int w, input int d, input logic md, input logic [7:0] thr);
      for (int y = 0; y < d; y++) begin
         for (int x = 0; x < w; x++) begin
            int         v;
            int         gx;
            int         gy;
            int         mag;
            logic [8:0] e;
            v = 0;
            if (x != 0 && x != w-1 && y != 0 && y != d-1) begin
               gx = (px(x+1, y-1, w) + 2*px(x+1, y, w) + px(x+1, y+1, w))
                  - (px(x-1, y-1, w) + 2*px(x-1, y, w) + px(x-1, y+1, w));
               gy = (px(x-1, y+1, w) + 2*px(x, y+1, w) + px(x+1, y+1, w))
                  - (px(x-1, y-1, w) + 2*px(x, y-1, w) + px(x+1, y-1, w));
               mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
               if (md) v = (mag > 255) ? 255 : mag;
               else    v = (mag > int'(thr)) ? 255 : 0;
            end
            e[8]   = (x == w-1) && (y == d-1);
            e[7:0] = 8'(v);
            exp_q.push_back(e);
         end
      end
   endfunction

   // Queue a frame from fr[]; with noisy set, threshold/mode wander on every
   // pixel except pixel 0 and must have no effect.
   task automatic push_drv(input int n, input logic md, input logic [7:0] thr, input bit noisy);
      for (int i = 0; i < n; i++) begin
         drv_t t;
         t.d = fr[i];
         if (i == 0 || !noisy) begin
            t.thr = thr;
            t.md  = md;
         end else begin
            t.thr = 8'($urandom);
            t.md  = 1'($urandom);
         end
         drv_q.push_back(t);
      end
   endtask

   // ---------------- driver / monitor ----------------
   task automatic run_stream(input int sel, input int pv, input int pr, input bit chk_lat,
                             input int max_out, input string tag);
      int         w;
      int         n;
      int         cyc;
      int         outs;
      bit         held;
      bit         lat_done;
      bit         prev_last;
      logic [7:0] hd;
      logic       hl;
      logic [8:0] e;
      w         = (sel == 1) ? 8 : 4;
      n         = w * ((sel == 1) ? 6 : 4);
      cyc       = 0;
      outs      = 0;
      held      = 0;
      lat_done  = 0;
      prev_last = 0;
      hd        = 8'h00;
      hl        = 1'b0;
      while ((drv_q.size() > 0 || exp_q.size() > 0) && (max_out == 0 || outs < max_out)) begin
         if (cyc >= 5000) begin
            n_chk++;
            n_err++;
            $display("FAIL timeout %s: got %0d outputs pending expected 0", tag, exp_q.size());
            break;
         end
         cyc++;
         @(negedge clk);
         if (drv_q.size() > 0) begin
            in_valid[sel] = ($urandom_range(99) < pv);
            in_data[sel]  = drv_q[0].d;
            threshold     = drv_q[0].thr;
            mode          = drv_q[0].md;
         end else begin
            in_valid[sel] = 1'b0;
            in_data[sel]  = 8'($urandom);
         end
         out_ready[sel] = ($urandom_range(99) < pr);
         #1;
         if (held) begin
            check({tag, " stall valid"}, int'(out_valid[sel]), 1);
            check({tag, " stall data"}, int'(out_data[sel]), int'(hd));
            check({tag, " stall last"}, int'(out_last[sel]), int'(hl));
         end
         if (out_valid[sel] && !out_ready[sel])
            check({tag, " stall in_ready"}, int'(in_ready[sel]), 0);
         if (flushing)
            check({tag, " flush in_ready"}, int'(in_ready[sel]), 0);
         if (prev_last && in_valid[sel])
            check({tag, " turnaround in_ready"}, int'(in_ready[sel]), 1);
         if (chk_lat && !lat_done && out_valid[sel]) begin
            check({tag, " first output latency"}, acc_cnt, w + 2);
            lat_done = 1;
         end
         prev_last = 0;
         if (in_valid[sel] && in_ready[sel]) begin
            void'(drv_q.pop_front());
            if (acc_cnt % n == n - 1) flushing = 1;
            acc_cnt++;
         end
         if (out_valid[sel] && out_ready[sel]) begin
            outs++;
            if (exp_q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL %s extra output: got data %0d expected none", tag, out_data[sel]);
            end else begin
               e = exp_q.pop_front();
               check({tag, " out data"}, int'(out_data[sel]), int'(e[7:0]));
               check({tag, " out last"}, int'(out_last[sel]), int'(e[8]));
            end
            if (out_last[sel]) begin
               flushing  = 0;
               prev_last = 1;
            end
         end
         held = out_valid[sel] && !out_ready[sel];
         hd   = out_data[sel];
         hl   = out_last[sel];
      end
      @(negedge clk);
      in_valid[sel]  = 1'b0;
      out_ready[sel] = 1'b1;
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst_n = 1'b0;
      for (int s = 0; s < 2; s++) begin
         in_valid[s]  = 1'b0;
         out_ready[s] = 1'b1;
      end
      for (int c = 0; c < cycles; c++) begin
         #1;
         for (int s = 0; s < 2; s++) begin
            check("reset out_valid", int'(out_valid[s]), 0);
            check("reset out_data", int'(out_data[s]), 0);
            check("reset out_last", int'(out_last[s]), 0);
         end
         @(negedge clk);
      end
      rst_n = 1'b1;
      drv_q.delete();
      exp_q.delete();
      acc_cnt  = 0;
      flushing = 0;
      #1;
      for (int s = 0; s < 2; s++)
         check("in_ready after reset", int'(in_ready[s]), 1);
   endtask

   task automatic fill_random(input int style);
      for (int i = 0; i < 48; i++) begin
         case (style)
            0:       fr[i] = 8'($urandom);
            1:       fr[i] = 8'($urandom_range(15));
            default: fr[i] = $urandom_range(1) ? 8'hFF : 8'h00;
         endcase
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      n_chk     = 0;
      n_err     = 0;
      acc_cnt   = 0;
      flushing  = 0;
      threshold = 8'h00;
      mode      = 1'b0;
      rst_n     = 1'b0;
      for (int s = 0; s < 2; s++) begin
         in_valid[s]  = 1'b0;
         in_data[s]   = 8'h00;
         out_ready[s] = 1'b1;
      end

      // pattern: 0 = flat 100, 1 = columns 2-3 at 10, 2 = columns 2-3 at 200
      vt[0] = '{0, 1'b1, 8'd0,   8'd0};
      vt[1] = '{1, 1'b1, 8'd0,   8'd40};
      vt[2] = '{1, 1'b0, 8'd40,  8'd0};
      vt[3] = '{1, 1'b0, 8'd39,  8'd255};
      vt[4] = '{2, 1'b1, 8'd0,   8'd255};
      vt[5] = '{2, 1'b0, 8'd254, 8'd255};
      vt[6] = '{1, 1'b0, 8'd0,   8'd255};
      vt[7] = '{0, 1'b0, 8'd0,   8'd0};

      do_reset(3);

      // 4x4 table frames, back to back, full throughput
      for (int v = 0; v < 8; v++) begin
         for (int i = 0; i < 16; i++) begin
            int x;
            x = i % 4;
            case (vt[v].pat)
               0:       fr[i] = 8'd100;
               1:       fr[i] = (x < 2) ? 8'd0 : 8'd10;
               default: fr[i] = (x < 2) ? 8'd0 : 8'd200;
            endcase
         end
         push_drv(16, vt[v].md, vt[v].thr, 0);
         for (int i = 0; i < 16; i++) begin
            int         x;
            int         y;
            logic [8:0] e;
            x      = i % 4;
            y      = i / 4;
            e[8]   = (i == 15);
            e[7:0] = (x >= 1 && x <= 2 && y >= 1 && y <= 2) ? vt[v].exp_in : 8'd0;
            exp_q.push_back(e);
         end
      end
      run_stream(0, 100, 100, 1, 0, "table");

      // 4x4 step frame under heavy output backpressure
      for (int i = 0; i < 16; i++) fr[i] = ((i % 4) < 2) ? 8'd0 : 8'd10;
      push_drv(16, 1'b1, 8'd0, 1);
      model_frame(4, 4, 1'b1, 8'd0);
      run_stream(0, 100, 25, 0, 0, "table stall");

      // random 8x6 frames, two per stream
      for (int r = 0; r < 3; r++) begin
         for (int f = 0; f < 2; f++) begin
            logic       md;
            logic [7:0] thr;
            md  = 1'($urandom);
            thr = (r == 1) ? 8'($urandom_range(60)) : 8'($urandom);
            fill_random((r + f) % 3);
            push_drv(48, md, thr, 1);
            model_frame(8, 6, md, thr);
         end
         run_stream(1, $urandom_range(40, 100), $urandom_range(30, 100), 0, 0, "random");
      end

      // reset partway through a frame, then two clean frames
      fill_random(0);
      push_drv(48, 1'b1, 8'd0, 1);
      model_frame(8, 6, 1'b1, 8'd0);
      run_stream(1, 80, 80, 0, 10, "pre-reset");
      do_reset(2);
      for (int f = 0; f < 2; f++) begin
         logic [7:0] thr;
         thr = 8'($urandom_range(10, 120));
         fill_random(f);
         push_drv(48, f[0], thr, 1);
         model_frame(8, 6, f[0], thr);
      end
      run_stream(1, 70, 60, 0, 0, "post-reset");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/sobel_stream.md
# sobel_stream

Streaming, parametrised Sobel edge detector for the edge-detection pipeline. It accepts one 8-bit greyscale pixel per handshake in raster order, keeps two line buffers and a 3x3 window, and emits exactly one output pixel per input pixel. Each output is either a saturated gradient magnitude or a thresholded binary edge value. Valid/ready handshakes on both sides let it sit between the frame reader and the bitmap writer, and it processes back-to-back frames without a full-frame store.

## Interface
- WIDTH, 640: pixels per line; must be ≥ 3.
- DEPTH, 480: lines per frame; must be ≥ 3.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- threshold  input  8  edge threshold; sampled on acceptance of pixel 0 of each frame.
- mode  input  1  output mode, 0 = binary edge, 1 = saturated magnitude; sampled with threshold.
- in_valid  input  1  in_data is valid.
- in_data  input  8  input pixel, raster order, unsigned.
- in_ready  output  1  block accepts in_data this cycle.
- out_valid  output  1  out_data is valid.
- out_data  output  8  result pixel.
- out_last  output  1  asserted with the final pixel of a frame (index WIDTH*DEPTH-1).
- out_ready  input  1  downstream accepts out_data this cycle.

## Operation
- Transfers occur on the rising edge when valid && ready on the respective side. Input index k = y*WIDTH+x.
- Window: two WIDTH-deep line buffers plus a 3x3 shift window. Output k is computable once input k+WIDTH+1 has been accepted.
- Gx = (p[x+1][y-1] + 2p[x+1][y] + p[x+1][y+1]) − (same terms at column x−1).
- Gy = (row y+1 terms) − (row y−1 terms).
- Use 11-bit signed intermediates. mag = |Gx| + |Gy|, range 0..2040, 11 bits unsigned.
- Mode 1: out_data = min(mag, 255).
- Mode 0: out_data = 255 if mag > threshold (strict, full-width compare), else 0.
- Border pixels (x = 0, x = WIDTH−1, y = 0, y = DEPTH−1) always output 0 in both modes.
- State machine:
  - FILL: accept inputs 0..WIDTH, produce no output. Go to RUN after input WIDTH is accepted.
  - RUN: each accepted input k loads output k−WIDTH−1 into the output register. After input WIDTH*DEPTH−1 is accepted, go to FLUSH.
  - FLUSH: in_ready = 0. Emit the remaining WIDTH+1 outputs (all bottom-border or last-column zeros), one per out handshake. After the out_last transfer, go to FILL for the next frame.
- Input and output counters wrap to 0 at WIDTH*DEPTH−1. There is no other frame delimiter.
- threshold and mode changes mid-frame have no effect until the next frame's pixel 0.

## Timing
- Reset (asynchronous assert, synchronous release): state = FILL, counters = 0, out_valid = 0, out_data = 0, out_last = 0. in_ready = 1 from the first cycle after reset release.
- in_ready by state:
  - FILL: 1.
  - RUN: !out_valid || out_ready.
  - FLUSH: 0.
- Latency: output k becomes valid on the edge that accepts input k+WIDTH+1. In FLUSH, each subsequent output is valid one cycle after the prior out transfer, or back-to-back when out_ready is held high.
- Backpressure: while out_valid && !out_ready, out_data and out_last are held stable and no input is accepted in RUN.
- Throughput: 1 pixel/cycle sustained with in_valid and out_ready both high.
- Frame turnaround: the first input of the next frame is accepted in the cycle after the out_last transfer.
- Reset mid-frame: all partial frame state is discarded immediately, with no output glitch past the reset value. The next accepted pixel is pixel 0.
- Line buffer contents are not reset and need not be. Border forcing guarantees no stale data reaches the output.

## Test plan
- Flat frame (WIDTH=4, DEPTH=4, all pixels 100, mode 1, out_ready=1) -> 16 outputs, all 0. out_last only on output 15. First output valid on the edge accepting input 5.
- Vertical step (4x4; columns 0–1 = 0, columns 2–3 = 10; mode 1) -> interior (1,1), (2,1), (1,2), (2,2) = 40, border = 0.
- Same frame in mode 0: threshold 40 gives all outputs 0; threshold 39 gives interior = 255.
- Strong step (columns 2–3 = 200, mode 1) -> interior 255 (mag 800 saturated). Mode 0 with threshold 254 -> interior 255.
- Random 8x6 frames with random in_valid/out_ready toggling -> output stream bit-exact to a software model. Data and last are held stable under stall. No input accepted in FLUSH.
- Two back-to-back frames with reset pulsed mid-way through the first -> out_valid = 0 during reset. The subsequent frame output matches the model from pixel 0. threshold changed mid-frame applies only from the next frame.
